fir_coeff_loader: RTL and testbench
===================================

# fir_coeff_loader

Coefficient staging block that sits directly upstream of the scope's FIR filter and drives its packed coefficient bus. Accepts a new coefficient set as a stream of words over a valid/ready handshake into a shadow bank. Swaps the shadow bank into the active bank atomically on a sample strobe, so the filter never sees a partially updated set mid-sample.

## Interface
- NUM_TAPS, 4, number of filter taps (≥2)
- COEFF_WIDTH, 8, bits per signed coefficient
- DEFAULT_COEFFS, {NUM_TAPS{8'sd1}} sized COEFF_WIDTH*NUM_TAPS, active bank value after reset

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- load_start  in  1  one-cycle pulse; begins a new load
- coeff_valid  in  1  coeff_data holds a word
- coeff_data  in  COEFF_WIDTH  signed coefficient word
- coeff_ready  out  1  block accepts a word this cycle
- sample_strobe  in  1  one-cycle pulse per filter input sample
- packed_coeffs  out  COEFF_WIDTH*NUM_TAPS  active bank; tap k at bits [COEFF_WIDTH*k +: COEFF_WIDTH]
- busy  out  1  state ≠ IDLE
- swap_done  out  1  one-cycle pulse when active bank is updated
- load_error  out  1  one-cycle pulse when a load is restarted

## Operation
- States: IDLE, LOAD, ARMED.
- IDLE: coeff_ready=0. On load_start → LOAD, word index idx=0.
- LOAD: coeff_ready=1. Each cycle with coeff_valid&&coeff_ready writes coeff_data to shadow[idx] and increments idx. The write at idx=LAST_IDX goes → ARMED.
  - LAST_IDX = NUM_TAPS-1, or the symmetric-mode value below.
- ARMED: coeff_ready=0. On sample_strobe: active ← shadow, pulse swap_done, → IDLE.
- load_start in LOAD or ARMED: pulse load_error, idx=0 → LOAD. Shadow contents are not cleared; the active bank is untouched. A word presented on the same cycle is discarded.
- load_start has priority over sample_strobe and coeff_valid in the same cycle.
- sample_strobe outside ARMED has no effect.
- Reset: state=IDLE, idx=0, shadow=DEFAULT_COEFFS, packed_coeffs=DEFAULT_COEFFS, coeff_ready=0, busy=0, swap_done=0, load_error=0.
- Coefficients are stored and passed bit-exact; no sign extension or saturation is applied.
- packed_coeffs is driven straight from registers, with no combinational path from any input.

## Timing
- load_start sampled at edge N → coeff_ready=1 from edge N onward, so the first word can be accepted at edge N+1.
- Each word takes one cycle when coeff_valid is held high. A full load takes LAST_IDX+1 accepting cycles.
- coeff_ready falls at the same edge that accepts the last word.
- A sample_strobe coincident with the last word is ignored. The swap waits for the next strobe seen in ARMED.
- Swap latency:
  - the strobe is sampled at edge M;
  - the new packed_coeffs value and swap_done=1 are both visible after edge M;
  - swap_done clears after edge M+1.
- load_error is high for the single cycle following the restarting edge.
- If rst asserts mid-load or in ARMED, the block returns immediately to the reset values. The partial load is lost and the active bank becomes DEFAULT_COEFFS.

## Configuration
- FIR_COEFF_SYM_EN defined: symmetric (linear-phase) mode.
  - A load takes ceil(NUM_TAPS/2) words, so LAST_IDX = ceil(NUM_TAPS/2)-1.
  - Word k is written to shadow taps k and NUM_TAPS-1-k in the same cycle. The middle tap of an odd NUM_TAPS is written once.
- FIR_COEFF_SYM_EN undefined: NUM_TAPS words are loaded, with word k written to tap k only.

## Test plan
- Reset with DEFAULT_COEFFS=32'h01010101 → packed_coeffs=32'h01010101, coeff_ready=0, busy=0. Asserting rst mid-load restores the same value immediately, asynchronously to clk.
- Load words 8'h10, 8'h20, 8'h30, 8'h40 back-to-back → coeff_ready high for exactly 4 accept cycles and packed_coeffs unchanged. The next sample_strobe yields packed_coeffs=32'h40302010 plus a one-cycle swap_done.
- Hold coeff_valid low for 3 cycles between words 2 and 3 → no extra writes. The final set is still 32'h40302010 after the strobe.
- In LOAD after 2 words, pulse load_start → load_error pulse, idx resets to 0. Loading 8'hAA, 8'hBB, 8'hCC, 8'hDD then a strobe → 32'hDDCCBBAA.
- sample_strobe on the same cycle as the 4th word → no swap. A strobe 5 cycles later swaps, and no swap_done appears before it.
- With FIR_COEFF_SYM_EN, load 8'h05, 8'h07 then a strobe → packed_coeffs=32'h05070705, with exactly 2 accept cycles.

Source files
------------

// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: stages a FIR coefficient set into a shadow bank over a
// valid/ready word stream, then swaps it into the active bank on the next
// sample strobe so the filter never sees a half-written set.
//
// Optional feature macro: FIR_COEFF_SYM_EN
//   defined   -> symmetric mode, ceil(NUM_TAPS/2) words, word k mirrored to
//                taps k and NUM_TAPS-1-k
//   undefined -> NUM_TAPS words, word k written to tap k only
//
// state | meaning
// IDLE  | waiting for load_start, active bank stable
// LOAD  | accepting coefficient words into the shadow bank
// ARMED | shadow bank complete, waiting for sample_strobe to swap
module fir_coeff_loader #(
  parameter int NUM_TAPS    = 4,
  parameter int COEFF_WIDTH = 8,
  parameter logic [COEFF_WIDTH*NUM_TAPS-1:0] DEFAULT_COEFFS = {NUM_TAPS{8'sd1}}
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load_start,
  input  logic                            coeff_valid,
  input  logic [COEFF_WIDTH-1:0]          coeff_data,
  output logic                            coeff_ready,
  input  logic                            sample_strobe,
  output logic [COEFF_WIDTH*NUM_TAPS-1:0] packed_coeffs,
  output logic                            busy,
  output logic                            swap_done,
  output logic                            load_error
);

  localparam int IDX_W = $clog2(NUM_TAPS);
`ifdef FIR_COEFF_SYM_EN
  localparam int LAST_IDX = (NUM_TAPS + 1) / 2 - 1;
`else
  localparam int LAST_IDX = NUM_TAPS - 1;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, ARMED} state_t;

  state_t                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [COEFF_WIDTH*NUM_TAPS-1:0] shadow_q, shadow_d;
  logic [COEFF_WIDTH*NUM_TAPS-1:0] active_q, active_d;
  logic                            swap_q, swap_d;
  logic                            err_q, err_d;

  // State, index, both banks and the pulse outputs are all registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= DEFAULT_COEFFS;
      active_q <= DEFAULT_COEFFS;
      swap_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      swap_q   <= swap_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic; load_start overrides both word writes and strobes.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    active_d = active_q;
    swap_d   = 1'b0;
    err_d    = 1'b0;
    if (load_start) begin
      err_d   = (state_q != IDLE);
      state_d = LOAD;
      idx_d   = '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (coeff_valid) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
`ifdef FIR_COEFF_SYM_EN
              if (idx_q == IDX_W'(k) || idx_q == IDX_W'(NUM_TAPS - 1 - k))
                shadow_d[k*COEFF_WIDTH +: COEFF_WIDTH] = coeff_data;
`else
              if (idx_q == IDX_W'(k))
                shadow_d[k*COEFF_WIDTH +: COEFF_WIDTH] = coeff_data;
`endif
            end
            if (idx_q == IDX_W'(LAST_IDX)) begin
              state_d = ARMED;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        ARMED: begin
          if (sample_strobe) begin
            active_d = shadow_q;
            swap_d   = 1'b1;
            state_d  = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign coeff_ready   = (state_q == LOAD);
  assign busy          = (state_q != IDLE);
  assign packed_coeffs = active_q;
  assign swap_done     = swap_q;
  assign load_error    = err_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader with hand-computed expected banks.
module tb_fir_coeff_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic        coeff_valid = 1'b0;
  logic [7:0]  coeff_data = 8'h00;
  logic        coeff_ready;
  logic        sample_strobe = 1'b0;
  logic [31:0] packed_coeffs;
  logic        busy;
  logic        swap_done;
  logic        load_error;

  int checks = 0;
  int failures = 0;
  int accepted = 0;

  fir_coeff_loader #(
    .NUM_TAPS(4), .COEFF_WIDTH(8), .DEFAULT_COEFFS(32'h01010101)
  ) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .coeff_valid(coeff_valid),
    .coeff_data(coeff_data), .coeff_ready(coeff_ready), .sample_strobe(sample_strobe),
    .packed_coeffs(packed_coeffs), .busy(busy), .swap_done(swap_done),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] d);
    coeff_valid = 1'b1;
    coeff_data  = d;
    if (coeff_ready) accepted++;
    step();
    coeff_valid = 1'b0;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  task automatic strobe();
    sample_strobe = 1'b1;
    step();
    sample_strobe = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (packed_coeffs !== 32'h01010101) begin failures++; $display("FAIL reset_packed got=%h exp=%h", packed_coeffs, 32'h01010101); end
    checks++; if (coeff_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", coeff_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (swap_done !== 1'b0 || load_error !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b%b exp=00", swap_done, load_error); end
    rst = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic_load();
    start_load();
    checks++; if (coeff_ready !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL basic_ready_after_start got=%b%b exp=11", coeff_ready, busy); end
    accepted = 0;
    send_word(8'h10); send_word(8'h20); send_word(8'h30); send_word(8'h40);
    checks++; if (accepted !== 4) begin failures++; $display("FAIL basic_accepts got=%0d exp=4", accepted); end
    checks++; if (coeff_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL basic_armed got=%b%b exp=01", coeff_ready, busy); end
    step(); step();
    checks++; if (packed_coeffs !== 32'h01010101 || swap_done !== 1'b0) begin failures++; $display("FAIL basic_preswap got=%h/%b exp=01010101/0", packed_coeffs, swap_done); end
    strobe();
    checks++; if (packed_coeffs !== 32'h40302010) begin failures++; $display("FAIL basic_swap got=%h exp=40302010", packed_coeffs); end
    checks++; if (swap_done !== 1'b1) begin failures++; $display("FAIL basic_swap_done got=%b exp=1", swap_done); end
    step();
    checks++; if (swap_done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL basic_after_swap got=%b%b exp=00", swap_done, busy); end
  endtask

  task automatic test_restart();
    start_load();
    send_word(8'h11); send_word(8'h22);
    load_start = 1'b1; coeff_valid = 1'b1; coeff_data = 8'h99;
    step();
    load_start = 1'b0; coeff_valid = 1'b0;
    checks++; if (load_error !== 1'b1) begin failures++; $display("FAIL restart_error got=%b exp=1", load_error); end
    checks++; if (coeff_ready !== 1'b1) begin failures++; $display("FAIL restart_ready got=%b exp=1", coeff_ready); end
    step();
    checks++; if (load_error !== 1'b0) begin failures++; $display("FAIL restart_error_clear got=%b exp=0", load_error); end
    accepted = 0;
    send_word(8'hAA); send_word(8'hBB); send_word(8'hCC); send_word(8'hDD);
    checks++; if (accepted !== 4 || coeff_ready !== 1'b0) begin failures++; $display("FAIL restart_accepts got=%0d/%b exp=4/0", accepted, coeff_ready); end
    checks++; if (packed_coeffs !== 32'h40302010) begin failures++; $display("FAIL restart_active_kept got=%h exp=40302010", packed_coeffs); end
    strobe();
    checks++; if (packed_coeffs !== 32'hDDCCBBAA) begin failures++; $display("FAIL restart_swap got=%h exp=DDCCBBAA", packed_coeffs); end
    step();
  endtask

  task automatic test_gap();
    start_load();
    send_word(8'h10); send_word(8'h20);
    coeff_data = 8'hEE;
    for (int i = 0; i < 3; i++) step();
    checks++; if (coeff_ready !== 1'b1) begin failures++; $display("FAIL gap_ready got=%b exp=1", coeff_ready); end
    send_word(8'h30); send_word(8'h40);
    checks++; if (coeff_ready !== 1'b0) begin failures++; $display("FAIL gap_armed got=%b exp=0", coeff_ready); end
    strobe();
    checks++; if (packed_coeffs !== 32'h40302010) begin failures++; $display("FAIL gap_swap got=%h exp=40302010", packed_coeffs); end
    step();
  endtask

  task automatic test_coincident_strobe();
    int early;
    strobe();
    checks++; if (swap_done !== 1'b0) begin failures++; $display("FAIL idle_strobe got=%b exp=0", swap_done); end
    start_load();
    send_word(8'h01); send_word(8'h02); send_word(8'h03);
    sample_strobe = 1'b1;
    send_word(8'h04);
    sample_strobe = 1'b0;
    checks++; if (swap_done !== 1'b0 || packed_coeffs !== 32'h40302010) begin failures++; $display("FAIL coinc_no_swap got=%b/%h exp=0/40302010", swap_done, packed_coeffs); end
    early = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (swap_done !== 1'b0) early++;
    end
    checks++; if (early !== 0) begin failures++; $display("FAIL coinc_early_swap got=%0d exp=0", early); end
    strobe();
    checks++; if (swap_done !== 1'b1 || packed_coeffs !== 32'h04030201) begin failures++; $display("FAIL coinc_swap got=%b/%h exp=1/04030201", swap_done, packed_coeffs); end
    step();
  endtask

  task automatic test_armed_restart();
    start_load();
    send_word(8'h55); send_word(8'h66); send_word(8'h77); send_word(8'h88);
    load_start = 1'b1; sample_strobe = 1'b1;
    step();
    load_start = 1'b0; sample_strobe = 1'b0;
    checks++; if (load_error !== 1'b1 || swap_done !== 1'b0) begin failures++; $display("FAIL armed_restart got=%b%b exp=10", load_error, swap_done); end
    checks++; if (packed_coeffs !== 32'h04030201 || coeff_ready !== 1'b1) begin failures++; $display("FAIL armed_restart_bank got=%h/%b exp=04030201/1", packed_coeffs, coeff_ready); end
    strobe();
    checks++; if (swap_done !== 1'b0 || packed_coeffs !== 32'h04030201) begin failures++; $display("FAIL load_strobe got=%b/%h exp=0/04030201", swap_done, packed_coeffs); end
  endtask

  task automatic test_rst_mid_load();
    send_word(8'h12); send_word(8'h34);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (packed_coeffs !== 32'h01010101) begin failures++; $display("FAIL async_rst_packed got=%h exp=01010101", packed_coeffs); end
    checks++; if (busy !== 1'b0 || coeff_ready !== 1'b0) begin failures++; $display("FAIL async_rst_state got=%b%b exp=00", busy, coeff_ready); end
    step();
    rst = 1'b0;
    step();
    checks++; if (busy !== 1'b0 || packed_coeffs !== 32'h01010101) begin failures++; $display("FAIL post_rst got=%b/%h exp=0/01010101", busy, packed_coeffs); end
  endtask

`ifdef FIR_COEFF_SYM_EN
  task automatic test_sym();
    start_load();
    accepted = 0;
    send_word(8'h05); send_word(8'h07);
    checks++; if (accepted !== 2 || coeff_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL sym_accepts got=%0d/%b%b exp=2/01", accepted, coeff_ready, busy); end
    strobe();
    checks++; if (packed_coeffs !== 32'h05070705 || swap_done !== 1'b1) begin failures++; $display("FAIL sym_swap got=%h/%b exp=05070705/1", packed_coeffs, swap_done); end
    step();
  endtask
`endif

  initial begin
    test_reset();
`ifdef FIR_COEFF_SYM_EN
    test_sym();
`else
    test_basic_load();
    test_restart();
    test_gap();
    test_coincident_strobe();
    test_armed_restart();
    test_rst_mid_load();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
